// File: rtl/axi_lite_master_rw_queue.sv
// AXI4-Lite master with a command FIFO and in-order responses.
// One read or write is in flight on the AXI port at a time.

module axi_lite_master_rw_queue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Extra pointer MSB distinguishes full from empty.
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Read/write pointers; reset flushes the queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Entry storage needs no reset: pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end

endmodule

module axi_lite_master_rw_queue #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int DEPTH          = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_strb_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_data_o,
    output logic                        rsp_err_o,
    output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    input  logic [1:0]                  b_resp_i,
    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]                  r_resp_i,
    input  logic                        r_valid_i,
    output logic                        r_ready_o
);

    localparam int STRB_W  = AXI_DATA_WIDTH / 8;
    localparam int ENTRY_W = 1 + AXI_ADDR_WIDTH + AXI_DATA_WIDTH + STRB_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WB,
        ST_RD,
        ST_RR,
        ST_RSP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic [ENTRY_W-1:0]        push_entry;
    logic [ENTRY_W-1:0]        head_entry;

    logic                      head_we;
    logic [AXI_ADDR_WIDTH-1:0] head_addr;
    logic [AXI_DATA_WIDTH-1:0] head_data;
    logic [STRB_W-1:0]         head_strb;

    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]         wstrb_q;
    logic                      aw_valid_q;
    logic                      w_valid_q;
    logic                      aw_left;
    logic                      w_left;
    logic [AXI_DATA_WIDTH-1:0] rsp_data_q;
    logic                      rsp_err_q;

    // Only bit 1 of a response separates OKAY/EXOKAY from errors.
    logic unused_resp_lsb;
    assign unused_resp_lsb = b_resp_i[0] ^ r_resp_i[0];

    // A full queue refuses commands even if a pop frees a slot.
    assign cmd_ready_o = !fifo_full;
    assign push        = cmd_valid_i && !fifo_full;
    assign push_entry  = {cmd_we_i, cmd_addr_i, cmd_data_i, cmd_strb_i};

    assign head_we   = head_entry[ENTRY_W-1];
    assign head_addr = head_entry[AXI_DATA_WIDTH+STRB_W +: AXI_ADDR_WIDTH];
    assign head_data = head_entry[STRB_W +: AXI_DATA_WIDTH];
    assign head_strb = head_entry[STRB_W-1:0];

    axi_lite_master_rw_queue_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (head_entry)
    );

    // A write channel is still owed if its valid is up without ready.
    assign aw_left = aw_valid_q && !aw_ready_i;
    assign w_left  = w_valid_q && !w_ready_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic and FIFO pop decision.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = head_we ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                if (!aw_left && !w_left) state_d = ST_WB;
            end
            ST_WB: begin
                if (b_valid_i) state_d = ST_RSP;
            end
            ST_RD: begin
                if (ar_ready_i) state_d = ST_RR;
            end
            ST_RR: begin
                if (r_valid_i) state_d = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // AXI request registers: loaded on pop, valids drop after handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
        end else if (pop) begin
            addr_q     <= head_addr;
            wdata_q    <= head_we ? head_data : '0;
            wstrb_q    <= head_we ? head_strb : '0;
            aw_valid_q <= head_we;
            w_valid_q  <= head_we;
        end else begin
            if (aw_valid_q && aw_ready_i) aw_valid_q <= 1'b0;
            if (w_valid_q && w_ready_i)   w_valid_q  <= 1'b0;
        end
    end

    // Response capture from B or R; held until the next capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (state_q == ST_WB && b_valid_i) begin
            rsp_data_q <= '0;
            rsp_err_q  <= b_resp_i[1];
        end else if (state_q == ST_RR && r_valid_i) begin
            rsp_data_q <= r_data_i;
            rsp_err_q  <= r_resp_i[1];
        end
    end

    assign aw_addr_o   = addr_q;
    assign ar_addr_o   = addr_q;
    assign w_data_o    = wdata_q;
    assign w_strb_o    = wstrb_q;
    assign aw_valid_o  = aw_valid_q;
    assign w_valid_o   = w_valid_q;
    assign ar_valid_o  = (state_q == ST_RD);
    assign b_ready_o   = (state_q == ST_WB);
    assign r_ready_o   = (state_q == ST_RR);
    assign rsp_valid_o = (state_q == ST_RSP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_axi_lite_master_rw_queue.sv
// Bench for axi_lite_master_rw_queue: scoreboard plus
// a memory-backed AXI4-Lite slave with selectable timing.
`timescale 1ns/1ps

module tb_axi_lite_master_rw_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [63:0] cmd_addr_i;
    logic [63:0] cmd_data_i;
    logic [7:0]  cmd_strb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_data_o;
    logic        rsp_err_o;
    logic [63:0] aw_addr_o;
    logic        aw_valid_o;
    logic        aw_ready_i;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        w_valid_o;
    logic        w_ready_i;
    logic [1:0]  b_resp_i;
    logic        b_valid_i;
    logic        b_ready_o;
    logic [63:0] ar_addr_o;
    logic        ar_valid_o;
    logic        ar_ready_i;
    logic [63:0] r_data_i;
    logic [1:0]  r_resp_i;
    logic        r_valid_i;
    logic        r_ready_o;

    axi_lite_master_rw_queue #(
        .AXI_ADDR_WIDTH (64),
        .AXI_DATA_WIDTH (64),
        .DEPTH          (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_strb_i  (cmd_strb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .aw_addr_o   (aw_addr_o),
        .aw_valid_o  (aw_valid_o),
        .aw_ready_i  (aw_ready_i),
        .w_data_o    (w_data_o),
        .w_strb_o    (w_strb_o),
        .w_valid_o   (w_valid_o),
        .w_ready_i   (w_ready_i),
        .b_resp_i    (b_resp_i),
        .b_valid_i   (b_valid_i),
        .b_ready_o   (b_ready_o),
        .ar_addr_o   (ar_addr_o),
        .ar_valid_o  (ar_valid_o),
        .ar_ready_i  (ar_ready_i),
        .r_data_i    (r_data_i),
        .r_resp_i    (r_resp_i),
        .r_valid_i   (r_valid_i),
        .r_ready_o   (r_ready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mmem [logic [63:0]];
    logic [63:0] smem [logic [63:0]];
    int          vectors = 0;
    int          misses  = 0;
    // slave timing: 0 zero-wait, 1 random, 2 AW ready after 3 waits, 3 AW stalled
    int          smode   = 0;
    bit          rr_rand = 0;
    bit          ovr_en  = 0;
    logic [63:0] ovr_data;
    logic [1:0]  ovr_resp;

    function automatic logic [63:0] dflt(input logic [63:0] a);
        return {a[31:0], ~a[31:0]};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] d,
                                          input logic [7:0]  s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Addresses with bit 13 set live in an error region of the slave.
    function automatic logic addr_err(input logic [63:0] a);
        return a[13];
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: every accepted command yields one response, in order.
    task automatic model_accept(input logic we, input logic [63:0] a,
                                input logic [63:0] d, input logic [7:0] s);
        exp_t e;
        logic [63:0] cur;
        cur = mmem.exists(a) ? mmem[a] : dflt(a);
        if (ovr_en) begin
            e.data = we ? 64'h0 : ovr_data;
            e.err  = ovr_resp[1];
        end else if (we) begin
            e.data = 64'h0;
            e.err  = addr_err(a);
            if (!e.err) mmem[a] = merge(cur, d, s);
        end else begin
            e.data = cur;
            e.err  = addr_err(a);
        end
        exp_q.push_back(e);
    endtask

    task automatic offer(input logic we, input logic [63:0] a,
                         input logic [63:0] d, input logic [7:0] s,
                         output bit acc);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = a;
        cmd_data_i  = d;
        cmd_strb_i  = s;
        acc = cmd_ready_o;
        if (acc) model_accept(we, a, d, s);
    endtask

    task automatic send(input logic we, input logic [63:0] a,
                        input logic [63:0] d, input logic [7:0] s);
        bit acc;
        int n;
        n = 0;
        offer(we, a, d, s, acc);
        while (!acc && n < 300) begin
            @(negedge clk_i);
            n++;
            offer(we, a, d, s, acc);
        end
        if (!acc) begin
            vectors++;
            misses++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
        end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: a response handshake pops and compares the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_ni && rsp_valid_o && rsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    misses++;
                    $display("FAIL rsp_unexpected: got data %h err %b expected none",
                             rsp_data_o, rsp_err_o);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data_o, e.data);
                    check("rsp_err", rsp_err_o, e.err);
                end
            end
        end
    end

    initial begin : rsp_ready_drv
        forever begin
            @(negedge clk_i);
            if (rr_rand) rsp_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // Slave: at each falling edge, retire the handshakes predicted at the
    // previous falling edge, drive new ready/valid, then predict again.
    initial begin : slave
        bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
        bit          s_aw, s_w, s_ar, err, lo;
        logic [63:0] c_awaddr, c_wdata, c_araddr, cur;
        logic [7:0]  c_wstrb;
        int          aw_cnt;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        s_aw = 0; s_w = 0; s_ar = 0; aw_cnt = 0;
        aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
        b_valid_i = 0; b_resp_i = 0; r_valid_i = 0;
        r_resp_i = 0; r_data_i = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                s_aw = 0; s_w = 0; s_ar = 0; aw_cnt = 0;
                aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
                b_valid_i = 0; r_valid_i = 0;
            end else begin
                if (aw_hs) s_aw = 1;
                if (w_hs)  s_w  = 1;
                if (ar_hs) s_ar = 1;
                if (b_hs)  b_valid_i = 0;
                if (r_hs)  r_valid_i = 0;
                if (s_aw && s_w && !b_valid_i &&
                    (smode != 1 || $urandom_range(0, 1) == 1)) begin
                    lo = 1'($urandom_range(0, 1));
                    if (ovr_en) begin
                        b_resp_i = ovr_resp;
                    end else begin
                        err = addr_err(c_awaddr);
                        b_resp_i = {err, lo};
                        cur = smem.exists(c_awaddr) ? smem[c_awaddr] : dflt(c_awaddr);
                        if (!err) smem[c_awaddr] = merge(cur, c_wdata, c_wstrb);
                    end
                    b_valid_i = 1;
                    s_aw = 0;
                    s_w  = 0;
                end
                if (s_ar && !r_valid_i &&
                    (smode != 1 || $urandom_range(0, 1) == 1)) begin
                    lo = 1'($urandom_range(0, 1));
                    if (ovr_en) begin
                        r_data_i = ovr_data;
                        r_resp_i = ovr_resp;
                    end else begin
                        r_data_i = smem.exists(c_araddr) ? smem[c_araddr] : dflt(c_araddr);
                        r_resp_i = {addr_err(c_araddr), lo};
                    end
                    r_valid_i = 1;
                    s_ar = 0;
                end
                aw_cnt = aw_valid_o ? aw_cnt + 1 : 0;
                case (smode)
                    1: begin
                        aw_ready_i = 1'($urandom_range(0, 1));
                        w_ready_i  = 1'($urandom_range(0, 1));
                        ar_ready_i = 1'($urandom_range(0, 1));
                    end
                    2: begin
                        aw_ready_i = (aw_cnt >= 4);
                        w_ready_i  = 1;
                        ar_ready_i = 1;
                    end
                    3: begin
                        aw_ready_i = 0;
                        w_ready_i  = 1;
                        ar_ready_i = 1;
                    end
                    default: begin
                        aw_ready_i = 1;
                        w_ready_i  = 1;
                        ar_ready_i = 1;
                    end
                endcase
                aw_hs = aw_valid_o && aw_ready_i;
                w_hs  = w_valid_o && w_ready_i;
                ar_hs = ar_valid_o && ar_ready_i;
                b_hs  = b_valid_i && b_ready_o;
                r_hs  = r_valid_i && r_ready_o;
                if (aw_hs) c_awaddr = aw_addr_o;
                if (w_hs) begin
                    c_wdata = w_data_o;
                    c_wstrb = w_strb_o;
                end
                if (ar_hs) c_araddr = ar_addr_o;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit acc;
        int acc_n, idx, aw_hi, w_hi, bad_addr, early_b, cnt;
        logic [63:0] saved [logic [63:0]];
        logic [63:0] a, d;

        rst_ni = 0;
        cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = 0;
        cmd_data_i = 0; cmd_strb_i = 0; rsp_ready_i = 1;
        repeat (3) @(negedge clk_i);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_valids", {aw_valid_o, w_valid_o, ar_valid_o,
                             b_ready_o, r_ready_o, rsp_valid_o}, 0);
        check("rst_rsp_data", rsp_data_o, 0);
        check("rst_rsp_err", rsp_err_o, 0);
        check("rst_aw_addr", aw_addr_o, 0);
        check("rst_w_data", w_data_o, 0);
        check("rst_w_strb", w_strb_o, 0);
        rst_ni = 1;
        @(negedge clk_i);

        // Zero-wait write latency.
        smode = 0;
        offer(1, 64'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF, acc);
        check("lat_accept", acc, 1);
        @(negedge clk_i);
        cmd_valid_i = 0;
        check("lat_n1_aw_valid", aw_valid_o, 0);
        @(negedge clk_i);
        check("lat_n2_valids", {aw_valid_o, w_valid_o}, 2'b11);
        check("lat_n2_aw_addr", aw_addr_o, 64'h1000);
        check("lat_n2_w_data", w_data_o, 64'hDEADBEEF_CAFEF00D);
        check("lat_n2_w_strb", w_strb_o, 8'hFF);
        @(negedge clk_i);
        check("lat_n3_b_ready", b_ready_o, 1);
        check("lat_n3_rsp_valid", rsp_valid_o, 0);
        @(negedge clk_i);
        check("lat_n4_rsp_valid", rsp_valid_o, 1);
        wait_drain("lat_drain");

        // Read with an overridden SLVERR reply.
        ovr_en = 1;
        ovr_data = 64'h01234567_89ABCDEF;
        ovr_resp = 2'b10;
        offer(0, 64'h2000, 64'h0, 8'h0, acc);
        check("rd_accept", acc, 1);
        @(negedge clk_i);
        cmd_valid_i = 0;
        @(negedge clk_i);
        check("rd_ar_valid", ar_valid_o, 1);
        check("rd_ar_addr", ar_addr_o, 64'h2000);
        @(negedge clk_i);
        @(negedge clk_i);
        check("rd_rsp_data", rsp_data_o, 64'h01234567_89ABCDEF);
        wait_drain("rd_drain");
        ovr_en = 0;

        // AW ready delayed by three cycles, W ready at once.
        smode = 2;
        offer(1, 64'h1008, 64'h1111_2222_3333_4444, 8'h0F, acc);
        check("awd_accept", acc, 1);
        aw_hi = 0; w_hi = 0; bad_addr = 0; early_b = 0; cnt = 0;
        @(negedge clk_i);
        cmd_valid_i = 0;
        while (!rsp_valid_o && cnt < 40) begin
            aw_hi += int'(aw_valid_o);
            w_hi  += int'(w_valid_o);
            if (aw_valid_o && aw_addr_o != 64'h1008) bad_addr++;
            if (b_ready_o && (aw_valid_o || aw_hi < 4)) early_b++;
            @(negedge clk_i);
            cnt++;
        end
        check("awd_rsp_seen", rsp_valid_o, 1);
        check("awd_aw_cycles", aw_hi, 4);
        check("awd_w_cycles", w_hi, 1);
        check("awd_addr_stable", bad_addr, 0);
        check("awd_early_b", early_b, 0);
        wait_drain("awd_drain");

        // Fill the queue with the response stalled.
        smode = 0;
        rsp_ready_i = 0;
        acc_n = 0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            a = 64'h100 + 64'(8 * idx);
            d = {$urandom, $urandom};
            offer(1, a, d, 8'hFF, acc);
            if (acc) begin
                acc_n++;
                idx++;
            end
            @(negedge clk_i);
        end
        check("fill_accepted", acc_n, 5);
        check("fill_cmd_ready", cmd_ready_o, 0);
        cmd_valid_i = 0;
        rsp_ready_i = 1;
        wait_drain("fill_drain");

        // Reset while AW is stalled with two commands queued.
        smode = 3;
        saved = mmem;
        for (int i = 0; i < 3; i++)
            send(1, 64'h180 + 64'(8 * i), {$urandom, $urandom}, 8'hFF);
        cnt = 0;
        while (!aw_valid_o && cnt < 20) begin
            @(negedge clk_i);
            cnt++;
        end
        check("rstm_aw_before", aw_valid_o, 1);
        check("rstm_queued", cmd_ready_o, 1);
        rst_ni = 0;
        #1;
        check("rstm_valids", {aw_valid_o, w_valid_o, ar_valid_o,
                              b_ready_o, r_ready_o, rsp_valid_o}, 0);
        check("rstm_cmd_ready", cmd_ready_o, 1);
        exp_q.delete();
        mmem = saved;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        smode = 0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            cnt += int'(rsp_valid_o) + int'(aw_valid_o) + int'(ar_valid_o);
        end
        check("rstm_quiet", cnt, 0);

        // Random traffic with random slave timing and response backpressure.
        smode = 1;
        rr_rand = 1;
        for (int i = 0; i < 300; i++) begin
            idx = $urandom_range(0, 11);
            a = (idx < 8) ? 64'h100 + 64'(8 * idx) : 64'h2000 + 64'(8 * (idx - 8));
            send(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end
        rr_rand = 0;
        @(negedge clk_i);
        rsp_ready_i = 1;
        wait_drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
